// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It inhibits the clock, issues a request-to-send,
// shifts a command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES     = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);
  localparam int INH_W = (CLK_INHIBIT_CYCLES > 1) ? $clog2(CLK_INHIBIT_CYCLES) : 1;
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_EDGE,
    ACK,
    WAIT_IDLE
  } state_t;

  // Two-flop synchronizers; reset to 1 so an idle bus never looks like a fall.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {ps2_data, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  logic clk_s2;
  logic data_s2;
  logic clk_s3_reg;
  logic fall;

  assign clk_s2  = pin_sync[0];
  assign data_s2 = pin_sync[1];
  assign fall    = clk_s3_reg & ~clk_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_s3_reg <= 1'b1;
    else     clk_s3_reg <= clk_s2;
  end

  state_t           state_reg,   state_next;
  logic [9:0]       shift_reg,   shift_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [GAP_W-1:0] gap_reg,     gap_next;
  logic             clk_oe_reg,  clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             done_reg,    done_next;
  logic             err_reg,     err_next;
  logic             to_reg,      to_next;
  logic             timed;

  assign timed = (state_reg == WAIT_EDGE) || (state_reg == ACK) || (state_reg == WAIT_IDLE);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    gap_next     = gap_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    to_next      = 1'b0;

    // A stalled device aborts the transfer even if an edge arrives this cycle.
    if (timed && (gap_reg == GAP_LAST)) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      to_next      = 1'b1;
      state_next   = IDLE;
    end else begin
      if (timed) gap_next = fall ? '0 : gap_reg + GAP_W'(1);
      case (state_reg)
        IDLE: begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          if (tx_valid) begin
            shift_next   = {1'b1, ~^tx_data, tx_data};
            inh_cnt_next = '0;
            bit_cnt_next = '0;
            gap_next     = '0;
            clk_oe_next  = 1'b1;
            state_next   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt_reg == INH_LAST) begin
            data_oe_next = 1'b1;
            state_next   = RTS;
          end else begin
            inh_cnt_next = inh_cnt_reg + INH_W'(1);
          end
        end
        RTS: begin
          clk_oe_next = 1'b0;
          gap_next    = '0;
          state_next  = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (fall) begin
            data_oe_next = ~shift_reg[0];
            shift_next   = {1'b0, shift_reg[9:1]};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd9) state_next = ACK;
          end
        end
        ACK: begin
          if (fall) begin
            if (data_s2) begin
              err_next   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          state_next   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      gap_reg     <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      to_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      gap_reg     <= gap_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      to_reg      <= to_next;
    end
  end

  assign tx_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_done     = done_reg;
  assign tx_ack_err  = err_reg;
  assign tx_timeout  = to_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that clocks
// at a 40-cycle half period, samples on rising edges and ACKs during clock 11.
module tb_ps2_host_tx;
  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;
  logic       dev_clk;
  logic       dev_data;

  int checks = 0;
  int errors = 0;

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_ack_err (tx_ack_err),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  // Wired-AND bus with pull-ups.
  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  // Pulse and event monitor, sampled on the falling system clock edge.
  int   cyc = 0, n_done = 0, n_err = 0, n_to = 0, n_multi = 0;
  int   done_cyc = -1, acc_cyc = -1, rel_cyc = -1, to_cyc = -1;
  logic prev_busy = 1'b0, prev_clk_oe = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (tx_ack_err === 1'b1) n_err <= n_err + 1;
    if (tx_timeout === 1'b1) begin
      n_to   <= n_to + 1;
      to_cyc <= cyc;
    end
    if ((int'(tx_done === 1'b1) + int'(tx_ack_err === 1'b1) + int'(tx_timeout === 1'b1)) > 1)
      n_multi <= n_multi + 1;
    if (busy === 1'b1 && prev_busy === 1'b0) acc_cyc <= cyc;
    if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) rel_cyc <= cyc;
    prev_busy   <= busy;
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic pulse_request(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for RTS, then generates nclk clock pulses.
  task automatic device_xfer(input int nclk, input bit do_ack,
                             output logic [9:0] bits, output logic start_bit);
    int w;
    bits      = '0;
    start_bit = 1'b1;
    w         = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 500) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 500) begin
      errors++;
      $display("FAIL dev_rts_wait: clk_oe=%b data_oe=%b required clk_oe=0 data_oe=1",
               ps2_clk_oe, ps2_data_oe);
      return;
    end
    repeat (10) @(negedge clk);
    start_bit = ps2_data;
    for (int i = 1; i <= nclk; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = ps2_data;
      if (i == 11) dev_data = 1'b1;
      if (i == 10 && do_ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data = 1'b0;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b busy=%b required ready=1 busy=0", tx_ready, busy);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    checks++;
    if ({tx_done, tx_ack_err, tx_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 000", {tx_done, tx_ack_err, tx_timeout});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send_ed();
    int         n, d0, e0, t0;
    logic [9:0] bits;
    logic       sb;
    d0 = n_done; e0 = n_err; t0 = n_to;
    pulse_request(8'hED);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != INH) begin
      errors++;
      $display("FAIL ed_inhibit_len: got %0d cycles required %0d", n, INH);
    end
    checks++;
    if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL ed_rts: clk_oe=%b data_oe=%b required 1 1", ps2_clk_oe, ps2_data_oe);
    end
    @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL ed_release: clk_oe=%b data_oe=%b required 0 1", ps2_clk_oe, ps2_data_oe);
    end
    device_xfer(11, 1'b1, bits, sb);
    checks++;
    if (sb !== 1'b0) begin
      errors++;
      $display("FAIL ed_start_bit: got %b required 0", sb);
    end
    checks++;
    if (bits !== 10'h3ED) begin
      errors++;
      $display("FAIL ed_bits: got %h required %h", bits, 10'h3ED);
    end
    checks++;
    if (n_done - d0 != 1 || n_err != e0 || n_to != t0) begin
      errors++;
      $display("FAIL ed_pulses: done=%0d err=%0d to=%0d required 1 0 0",
               n_done - d0, n_err - e0, n_to - t0);
    end
    checks++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL ed_idle: ready=%b clk_oe=%b data_oe=%b required 1 0 0",
               tx_ready, ps2_clk_oe, ps2_data_oe);
    end
    $display("txn 0xED bits=%h done=%0d", bits, n_done - d0);
  endtask

  task automatic test_back_to_back();
    int         d0;
    logic [9:0] b1, b2;
    logic       sb;
    d0       = n_done;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    device_xfer(11, 1'b1, b1, sb);
    tx_valid = 1'b0;
    checks++;
    if (acc_cyc != done_cyc + 1) begin
      errors++;
      $display("FAIL b2b_accept_cycle: accept at %0d required %0d", acc_cyc, done_cyc + 1);
    end
    device_xfer(11, 1'b1, b2, sb);
    repeat (5) @(negedge clk);
    checks++;
    if (b1 !== 10'h201) begin
      errors++;
      $display("FAIL b2b_first_bits: got %h required %h", b1, 10'h201);
    end
    checks++;
    if (b2 !== 10'h300) begin
      errors++;
      $display("FAIL b2b_second_bits: got %h required %h", b2, 10'h300);
    end
    checks++;
    if (n_done - d0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%0d busy=%b required 2 0", n_done - d0, busy);
    end
    $display("txn 0x01/0x00 bits=%h/%h done=%0d", b1, b2, n_done - d0);
  endtask

  task automatic test_ack_err();
    int         d0, e0;
    logic [9:0] bits;
    logic       sb;
    d0 = n_done; e0 = n_err;
    pulse_request(8'h5A);
    device_xfer(11, 1'b0, bits, sb);
    checks++;
    if (n_err - e0 != 1 || n_done != d0) begin
      errors++;
      $display("FAIL ackerr_pulses: err=%0d done=%0d required 1 0", n_err - e0, n_done - d0);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ackerr_idle: clk_oe=%b data_oe=%b ready=%b required 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    $display("txn 0x5A no-ack err=%0d", n_err - e0);
  endtask

  task automatic test_timeout();
    int d0, t0, w;
    d0 = n_done; t0 = n_to;
    pulse_request(8'h5A);
    w = 0;
    while (n_to == t0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (n_to - t0 != 1) begin
      errors++;
      $display("FAIL timeout_seen: got %0d pulses required 1", n_to - t0);
    end
    checks++;
    if (to_cyc - rel_cyc != TO) begin
      errors++;
      $display("FAIL timeout_gap: got %0d cycles required %0d", to_cyc - rel_cyc, TO);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || n_done != d0) begin
      errors++;
      $display("FAIL timeout_idle: clk_oe=%b data_oe=%b ready=%b done=%0d required 0 0 1 0",
               ps2_clk_oe, ps2_data_oe, tx_ready, n_done - d0);
    end
    $display("txn 0x5A no-clock timeout after %0d cycles", to_cyc - rel_cyc);
  endtask

  task automatic test_reset_mid();
    int         d0, e0, t0;
    logic [9:0] bits;
    logic       sb;
    d0 = n_done; e0 = n_err; t0 = n_to;
    pulse_request(8'h00);
    device_xfer(4, 1'b0, bits, sb);
    checks++;
    if (ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before: data_oe=%b clk_oe=%b busy=%b required 1 0 1",
               ps2_data_oe, ps2_clk_oe, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: clk_oe=%b data_oe=%b busy=%b required 0 0 0",
               ps2_clk_oe, ps2_data_oe, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || n_done != d0 || n_err != e0 || n_to != t0) begin
      errors++;
      $display("FAIL midrst_after: ready=%b pulses=%0d required 1 0", tx_ready,
               (n_done - d0) + (n_err - e0) + (n_to - t0));
    end
    pulse_request(8'hFF);
    device_xfer(11, 1'b1, bits, sb);
    checks++;
    if (bits !== 10'h3FF || n_done - d0 != 1) begin
      errors++;
      $display("FAIL midrst_resend: bits=%h done=%0d required %h 1", bits, n_done - d0, 10'h3FF);
    end
    $display("txn reset-abort then 0xFF bits=%h done=%0d", bits, n_done - d0);
  endtask

  task automatic test_valid_held();
    int         d0, e0, t0;
    logic [9:0] bits;
    logic       sb;
    d0 = n_done; e0 = n_err; t0 = n_to;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    fork
      device_xfer(11, 1'b1, bits, sb);
      begin
        for (int k = 0; k < 300; k++) begin
          tx_data = 8'(k * 37 + 3);
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    checks++;
    if (bits !== 10'h3A5) begin
      errors++;
      $display("FAIL held_bits: got %h required %h", bits, 10'h3A5);
    end
    checks++;
    if (n_done - d0 != 1 || n_err != e0 || n_to != t0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_pulses: done=%0d err=%0d to=%0d busy=%b required 1 0 0 0",
               n_done - d0, n_err - e0, n_to - t0, busy);
    end
    checks++;
    if (n_multi != 0) begin
      errors++;
      $display("FAIL pulse_overlap: got %0d overlapping cycles required 0", n_multi);
    end
    $display("txn 0xA5 held-valid bits=%h done=%0d", bits, n_done - d0);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_valid_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
